// File: rtl/tx_burst_scheduler_pkg.sv
// Shared types and constants for the TX burst scheduler: state encoding,
// word and channel widths, and the value DATA_IN takes out of reset.
package tx_burst_scheduler_pkg;

   localparam int unsigned WORD_W = 64;
   localparam int unsigned CH_W   = 3;
   localparam int unsigned CTR_W  = 4;
   localparam int unsigned MAX_CH = 8;

   localparam logic [1:0] IDLE_ENC  = 2'd0;
   localparam logic [1:0] GRANT_ENC = 2'd1;
   localparam logic [1:0] BURST_ENC = 2'd2;

   localparam logic [WORD_W-1:0] IDLE_WORD = '0;

   typedef enum logic [1:0] {
      IDLE  = IDLE_ENC,
      GRANT = GRANT_ENC,
      BURST = BURST_ENC
   } state_e;

endpackage

// File: rtl/tx_burst_scheduler_if.sv
// Channel request bus plus framer-side output bus of the burst scheduler.
// The master modport is the scheduler; slave is the channels/framer side.
interface tx_burst_scheduler_if
   import tx_burst_scheduler_pkg::*;
#(
   parameter int unsigned NUM_CH = 4
);

   logic [NUM_CH-1:0]        REQ_VALID;
   logic [NUM_CH*WORD_W-1:0] REQ_DATA;
   logic [NUM_CH-1:0]        REQ_LAST;
   logic [NUM_CH-1:0]        REQ_READY;
   logic                     DATA_IN_READY;
   logic [WORD_W-1:0]        DATA_IN;
   logic                     DATA_TO_SEND;
   logic [CH_W-1:0]          CHANNEL_OUT;
   logic                     BURST_END;

   modport master (
      input  REQ_VALID, REQ_DATA, REQ_LAST, DATA_IN_READY,
      output REQ_READY, DATA_IN, DATA_TO_SEND, CHANNEL_OUT, BURST_END
   );

   modport slave (
      output REQ_VALID, REQ_DATA, REQ_LAST, DATA_IN_READY,
      input  REQ_READY, DATA_IN, DATA_TO_SEND, CHANNEL_OUT, BURST_END
   );

endinterface

// File: rtl/tx_burst_scheduler_rr_pick.sv
// Round-robin picker: first requesting channel after `last`, wrapping
// modulo NUM_CH. Purely combinational.
module rr_pick
   import tx_burst_scheduler_pkg::*;
#(
   parameter int unsigned NUM_CH = 4
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   last,
   output logic [CH_W-1:0]   sel,
   output logic              any
);

   logic [MAX_CH-1:0] req_w;
   logic [CH_W-1:0]   idx;

   assign req_w = MAX_CH'(req);

   // Walk the search order backwards so the nearest requester wins.
   always_comb begin
      sel = '0;
      any = 1'b0;
      idx = '0;
      for (int k = int'(NUM_CH); k >= 1; k--) begin
         idx = CH_W'((int'(last) + k) % int'(NUM_CH));
         if (req_w[idx]) begin
            sel = idx;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_burst_scheduler.sv
// Grants one channel at a time to the framer in bursts of up to BURST_MAX
// words, round-robin between channels, forwarding each word one cycle later.
module tx_burst_scheduler
   import tx_burst_scheduler_pkg::*;
#(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned BURST_MAX = 8
) (
   input  logic                 USER_CLK,
   input  logic                 SYSTEM_RESET_N,
   tx_burst_scheduler_if.master bus
);

   state_e             state_q;
   logic [CH_W-1:0]    cur_ch_q;
   logic [CH_W-1:0]    last_ch_q;
   logic [CTR_W-1:0]   burst_ctr_q;
   logic [CTR_W-1:0]   burst_ctr_d;
   logic [WORD_W-1:0]  data_q;
   logic               send_q;
   logic [CH_W-1:0]    chan_q;
   logic               bend_q;

   logic [MAX_CH-1:0]  valid_w;
   logic [MAX_CH-1:0]  last_w;
   logic [MAX_CH-1:0]  ready_w;
   logic [WORD_W-1:0]  words [MAX_CH];
   logic [CH_W-1:0]    pick_sel;
   logic               pick_any;
   logic               accept_c;
   logic               burst_done_c;

   assign valid_w = MAX_CH'(bus.REQ_VALID);
   assign last_w  = MAX_CH'(bus.REQ_LAST);

   // Unpack the flat data bus into per-channel words, padded to MAX_CH.
   for (genvar g = 0; g < int'(MAX_CH); g++) begin : g_words
      if (g < int'(NUM_CH)) begin : g_used
         assign words[g] = bus.REQ_DATA[g*WORD_W +: WORD_W];
      end else begin : g_pad
         assign words[g] = IDLE_WORD;
      end
   end

   rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
      .req  (bus.REQ_VALID),
      .last (last_ch_q),
      .sel  (pick_sel),
      .any  (pick_any)
   );

   assign accept_c     = (state_q == BURST) && valid_w[cur_ch_q] && bus.DATA_IN_READY;
   assign burst_done_c = last_w[cur_ch_q] || (burst_ctr_q == CTR_W'(BURST_MAX - 1));
   assign burst_ctr_d  = burst_ctr_q + CTR_W'(1);
   assign ready_w      = accept_c ? (MAX_CH'(1) << cur_ch_q) : '0;

   assign bus.REQ_READY    = NUM_CH'(ready_w);
   assign bus.DATA_IN      = data_q;
   assign bus.DATA_TO_SEND = send_q;
   assign bus.CHANNEL_OUT  = chan_q;
   assign bus.BURST_END    = bend_q;

   always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
      if (!SYSTEM_RESET_N) begin
         state_q     <= IDLE;
         cur_ch_q    <= '0;
         last_ch_q   <= CH_W'(NUM_CH - 1);
         burst_ctr_q <= '0;
         data_q      <= IDLE_WORD;
         send_q      <= 1'b0;
         chan_q      <= '0;
         bend_q      <= 1'b0;
      end else begin
         send_q <= accept_c;
         bend_q <= accept_c && burst_done_c;
         if (accept_c) begin
            data_q <= words[cur_ch_q];
            chan_q <= cur_ch_q;
         end

         case (state_q)
            IDLE: begin
               if (|bus.REQ_VALID) state_q <= GRANT;
            end
            GRANT: begin
               if (pick_any) begin
                  cur_ch_q    <= pick_sel;
                  burst_ctr_q <= '0;
                  state_q     <= BURST;
               end else begin
                  state_q <= IDLE;
               end
            end
            BURST: begin
               // Stalls (no accept) hold the grant and the counter.
               if (accept_c) begin
                  burst_ctr_q <= burst_ctr_d;
                  if (burst_done_c) begin
                     last_ch_q <= cur_ch_q;
                     state_q   <= GRANT;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_burst_scheduler.sv
// Bench for tx_burst_scheduler: vector table, corner-case sequences and
// randomized traffic against a packet-level round-robin model.
module tb_tx_burst_scheduler;
   import tx_burst_scheduler_pkg::*;

   localparam int unsigned NCH  = 4;
   localparam int unsigned BMAX = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tx_burst_scheduler_if #(.NUM_CH(NCH)) bus ();

   tx_burst_scheduler #(.NUM_CH(NCH), .BURST_MAX(BMAX)) dut (
      .USER_CLK       (clk),
      .SYSTEM_RESET_N (rst_n),
      .bus            (bus)
   );

   typedef struct { logic [63:0] data; logic last; } cw_t;
   typedef struct { logic [63:0] data; int ch; logic fin; int cyc; } ow_t;
   typedef struct {
      logic [3:0] v; logic [3:0] l; logic dir; logic [63:0] d;
      logic [3:0] rdy; logic send; logic [2:0] ch; logic fin; logic [63:0] dout;
   } vec_t;

   cw_t chq [NCH][$];
   ow_t expq[$];
   ow_t obsq[$];
   int  blen[$];
   int  bch[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive_idle();
      bus.REQ_VALID     = '0;
      bus.REQ_DATA      = '0;
      bus.REQ_LAST      = '0;
      bus.DATA_IN_READY = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " REQ_READY"},    64'(bus.REQ_READY), 0);
      check({tag, " DATA_IN"},      bus.DATA_IN, 0);
      check({tag, " DATA_TO_SEND"}, 64'(bus.DATA_TO_SEND), 0);
      check({tag, " CHANNEL_OUT"},  64'(bus.CHANNEL_OUT), 0);
      check({tag, " BURST_END"},    64'(bus.BURST_END), 0);
   endtask

   task automatic do_reset();
      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic add_pkt(input int ch, input int len);
      cw_t w;
      for (int i = 0; i < len; i++) begin
         w.data = {$urandom(), $urandom()};
         w.last = (i == len - 1);
         chq[ch].push_back(w);
      end
   endtask

   function automatic bit queues_busy();
      for (int c = 0; c < int'(NCH); c++) if (chq[c].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   // Packet-level model: every non-empty channel requests; grants rotate from
   // the previous winner; a burst is a packet tail capped at BMAX words.
   task automatic build_expected();
      cw_t mq [NCH][$];
      int  last_ch = int'(NCH) - 1;
      expq.delete();
      for (int c = 0; c < int'(NCH); c++) mq[c] = chq[c];
      while (1) begin
         int  pick = -1;
         int  cnt  = 0;
         bit  fin  = 1'b0;
         cw_t w;
         ow_t o;
         for (int k = 1; k <= int'(NCH); k++)
            if (pick < 0 && mq[(last_ch + k) % int'(NCH)].size() > 0) pick = (last_ch + k) % int'(NCH);
         if (pick < 0) break;
         while (!fin) begin
            w = mq[pick].pop_front();
            cnt++;
            fin = w.last || (cnt == int'(BMAX));
            o.data = w.data; o.ch = pick; o.fin = fin; o.cyc = 0;
            expq.push_back(o);
         end
         last_ch = pick;
      end
   endtask

   task automatic run_traffic(input int pct, input int max_cyc, input string tag);
      int n = 0;
      logic [NCH-1:0]    acc, v, l;
      logic [NCH*64-1:0] d;
      ow_t o;
      obsq.delete();
      while (n < max_cyc && queues_busy()) begin
         v = '0; l = '0; d = '0;
         for (int c = 0; c < int'(NCH); c++) if (chq[c].size() > 0) begin
            v[c] = 1'b1;
            l[c] = chq[c][0].last;
            d[c*64 +: 64] = chq[c][0].data;
         end
         bus.REQ_VALID = v; bus.REQ_LAST = l; bus.REQ_DATA = d;
         bus.DATA_IN_READY = ($urandom_range(99) < 32'(pct));
         @(negedge clk);
         acc = bus.REQ_READY;
         check({tag, " ready legal"},
               64'(((acc & ~v) != 0) || (acc != 0 && !bus.DATA_IN_READY) || ($countones(acc) > 1)), 0);
         @(posedge clk);
         #1;
         n++;
         check({tag, " one-cycle latency"}, 64'(bus.DATA_TO_SEND), 64'(acc != 0));
         if (bus.DATA_TO_SEND) begin
            o.data = bus.DATA_IN; o.ch = int'(bus.CHANNEL_OUT); o.fin = bus.BURST_END; o.cyc = n;
            obsq.push_back(o);
         end
         for (int c = 0; c < int'(NCH); c++) if (acc[c] && chq[c].size() > 0) void'(chq[c].pop_front());
      end
      check({tag, " timeout"}, 64'(n >= max_cyc), 0);
      drive_idle();
      check({tag, " word count"}, 64'(obsq.size()), 64'(expq.size()));
      for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
         check({tag, " data"},      obsq[i].data, expq[i].data);
         check({tag, " channel"},   64'(obsq[i].ch), 64'(expq[i].ch));
         check({tag, " burst_end"}, 64'(obsq[i].fin), 64'(expq[i].fin));
      end
   endtask

   task automatic split_bursts();
      blen.delete(); bch.delete();
      for (int i = 0; i < obsq.size(); i++) begin
         if (i == 0 || obsq[i-1].fin) begin
            blen.push_back(0);
            bch.push_back(obsq[i].ch);
         end
         blen[blen.size()-1]++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[13];
      logic [63:0] a0 = 64'hC200_0000_0000_00A0, a1 = 64'hC200_0000_0000_00A1;
      logic [63:0] a2 = 64'hC200_0000_0000_00A2, a3 = 64'hC200_0000_0000_00A3;
      logic [63:0] a4 = 64'hC000_0000_0000_00A4;
      int cnt;
      int exp_len[6] = '{8, 8, 8, 8, 4, 4};
      int exp_ch[6]  = '{0, 1, 0, 1, 0, 1};
      int rr_ch[5]   = '{0, 1, 2, 3, 0};

      //            v     l     dir  d    rdy   send ch    fin   dout
      tbl[0]  = '{4'h4, 4'h0, 1'b1, a0, 4'h0, 1'b0, 3'd0, 1'b0, 64'h0};
      tbl[1]  = '{4'h4, 4'h0, 1'b1, a0, 4'h0, 1'b0, 3'd0, 1'b0, 64'h0};
      tbl[2]  = '{4'h4, 4'h0, 1'b1, a0, 4'h4, 1'b1, 3'd2, 1'b0, a0};
      tbl[3]  = '{4'h4, 4'h0, 1'b0, a1, 4'h0, 1'b0, 3'd2, 1'b0, a0};
      tbl[4]  = '{4'h4, 4'h0, 1'b0, a1, 4'h0, 1'b0, 3'd2, 1'b0, a0};
      tbl[5]  = '{4'h1, 4'h0, 1'b1, a1, 4'h0, 1'b0, 3'd2, 1'b0, a0};
      tbl[6]  = '{4'h4, 4'h0, 1'b1, a1, 4'h4, 1'b1, 3'd2, 1'b0, a1};
      tbl[7]  = '{4'h4, 4'h4, 1'b1, a2, 4'h4, 1'b1, 3'd2, 1'b1, a2};
      tbl[8]  = '{4'h0, 4'h0, 1'b1, a3, 4'h0, 1'b0, 3'd2, 1'b0, a2};
      tbl[9]  = '{4'h1, 4'h0, 1'b1, a3, 4'h0, 1'b0, 3'd2, 1'b0, a2};
      tbl[10] = '{4'h1, 4'h0, 1'b1, a3, 4'h0, 1'b0, 3'd2, 1'b0, a2};
      tbl[11] = '{4'h1, 4'h1, 1'b1, a4, 4'h1, 1'b1, 3'd0, 1'b1, a4};
      tbl[12] = '{4'h0, 4'h0, 1'b1, a4, 4'h0, 1'b0, 3'd0, 1'b0, a4};

      drive_idle();
      #1 check_zero("in reset");

      // Vector table: ch2 three-word packet with stalls, then ch0 after wrap.
      do_reset();
      for (int r = 0; r < 13; r++) begin
         bus.REQ_VALID     = tbl[r].v;
         bus.REQ_LAST      = tbl[r].l;
         bus.DATA_IN_READY = tbl[r].dir;
         for (int c = 0; c < int'(NCH); c++)
            bus.REQ_DATA[c*64 +: 64] = tbl[r].v[c] ? tbl[r].d : ~tbl[r].d;
         @(negedge clk);
         check($sformatf("row%0d REQ_READY", r), 64'(bus.REQ_READY), 64'(tbl[r].rdy));
         @(posedge clk);
         #1;
         check($sformatf("row%0d DATA_TO_SEND", r), 64'(bus.DATA_TO_SEND), 64'(tbl[r].send));
         check($sformatf("row%0d CHANNEL_OUT", r),  64'(bus.CHANNEL_OUT),  64'(tbl[r].ch));
         check($sformatf("row%0d BURST_END", r),    64'(bus.BURST_END),    64'(tbl[r].fin));
         check($sformatf("row%0d DATA_IN", r),      bus.DATA_IN,           tbl[r].dout);
      end
      drive_idle();

      // Two 20-word packets on ch0/ch1 split at BMAX with one bubble between bursts.
      do_reset();
      add_pkt(0, 20); add_pkt(1, 20);
      build_expected();
      run_traffic(100, 400, "maxburst");
      split_bursts();
      check("maxburst burst count", 64'(blen.size()), 6);
      for (int i = 0; i < 6 && i < blen.size(); i++) begin
         check($sformatf("maxburst len%0d", i), 64'(blen[i]), 64'(exp_len[i]));
         check($sformatf("maxburst ch%0d", i),  64'(bch[i]),  64'(exp_ch[i]));
      end
      for (int i = 0; i + 1 < obsq.size(); i++)
         check("maxburst spacing", 64'(obsq[i+1].cyc - obsq[i].cyc), obsq[i].fin ? 64'd2 : 64'd1);

      // All four channels busy from reset: grants rotate 0,1,2,3,0.
      do_reset();
      for (int c = 0; c < int'(NCH); c++) add_pkt(c, 20);
      build_expected();
      run_traffic(100, 800, "rr4");
      split_bursts();
      for (int i = 0; i < 5; i++)
         check($sformatf("rr4 burst%0d ch", i), (i < bch.size()) ? 64'(bch[i]) : 64'hFF, 64'(rr_ch[i]));

      // Reset during a ch3 burst, then ch0 wins against ch3.
      do_reset();
      bus.REQ_VALID = 4'h8; bus.REQ_DATA = {64'hD300_0000_0000_0003, 192'h0};
      bus.DATA_IN_READY = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20 && cnt < 3; i++) begin
         @(posedge clk);
         #1;
         if (bus.DATA_TO_SEND) begin
            cnt++;
            check("ch3 word channel", 64'(bus.CHANNEL_OUT), 3);
         end
      end
      check("ch3 three words", 64'(cnt), 3);
      #2 rst_n = 1'b0;
      #1 check_zero("async reset mid-burst");
      bus.REQ_VALID = 4'h9;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1 check("no accept after release", 64'(bus.REQ_READY), 0);
      @(posedge clk);
      #1 check("no send after release", 64'(bus.DATA_TO_SEND), 0);
      @(negedge clk) check("grant cycle ready", 64'(bus.REQ_READY), 0);
      @(negedge clk) check("ch0 granted first", 64'(bus.REQ_READY), 1);
      drive_idle();

      // Randomized traffic with random framer back-pressure.
      for (int round = 0; round < 3; round++) begin
         do_reset();
         for (int c = 0; c < int'(NCH); c++)
            for (int p = 0; p < int'($urandom_range(0, 3)); p++)
               add_pkt(c, int'($urandom_range(1, 14)));
         build_expected();
         run_traffic(70, 3000, $sformatf("rand%0d", round));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
